// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption core, one round per clock
module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cypher_text,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] ct_q, ct_d;

  logic [127:0] next_rk;
  logic [127:0] sub_shifted;
  logic [127:0] round_res;
  logic         accept;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) sits at index r + 4c, counted from the top of the word.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(rr+4*c) -: 8] = sbox(s[127-8*(rr+4*((c+rr)%4)) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign in_ready    = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign out_valid   = (fsm_q == DONE);
  assign busy        = (fsm_q == ROUND);
  assign cypher_text = ct_q;

  // Round datapath: the final round skips MixColumns.
  always_comb begin
    next_rk     = key_expand(rk_q, rcon_q);
    sub_shifted = sub_shift(state_q);
    round_res   = ((rnd_q == 4'd10) ? sub_shifted : mix_columns(sub_shifted)) ^ next_rk;
  end

  // Next-state logic: load on accept, iterate in ROUND, hold result in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = plain_text ^ key;
          rk_d    = key;
          rcon_d  = 8'h01;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_res;
        rk_d    = next_rk;
        rcon_d  = xtime(rcon_q);
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          ct_d  = round_res;
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
        if (accept) begin
          state_d = plain_text ^ key;
          rk_d    = key;
          rcon_d  = 8'h01;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - self-checking bench for aes128_encrypt_iter
module tb_aes128_encrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plain_text = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] cypher_text;
  logic         busy;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  aes128_encrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plain_text(plain_text), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .cypher_text(cypher_text), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference AES built from field arithmetic rather than a lookup table.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb;
      xb = x[7:0];
      inv = 0;
      for (int y = 1; y < 256; y++) begin
        if (xb != 0 && gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = u[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Transaction-level expectation: a block takes ten edges, then waits for out_ready.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_ct = '0;
  logic         exp_rdy;
  assign exp_rdy = (m_left == 0) && (!m_done || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_ct   <= m_pend;
      end
    end else if (in_valid && exp_rdy) begin
      m_pend <= aes_model(key, plain_text);
      m_left <= 10;
      m_done <= 1'b0;
    end else if (m_done && out_ready) begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the expectation.
  always @(negedge clk) begin
    check("in_ready", in_ready, exp_rdy);
    check("busy", busy, m_left > 0);
    check("out_valid", out_valid, m_done);
    if (m_done) check("cypher_text", cypher_text, m_ct);
  end

  task automatic wait_valid(input int max, input bit scramble, output int lat, output int nbusy);
    bit ok;
    lat = 0;
    nbusy = 0;
    ok = 1'b0;
    while (lat < max) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      lat++;
      if (scramble) begin
        #1;
        key = {$urandom, $urandom, $urandom, $urandom};
        plain_text = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check("out_valid timeout", ok, 1'b1);
  endtask

  task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input bit scramble);
    int lat, nb;
    @(posedge clk); #1;
    key = k; plain_text = p; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(30, scramble, lat, nb);
    check({name, " ct"}, cypher_text, exp);
    check({name, " latency"}, lat, 10);
    check({name, " busy cycles"}, nb, 10);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, nb, c1, c2;
    bit stable, rdy_low, ov_seen;
    logic [127:0] hold;

    build_sbox();
    check("model C.1", aes_model(C1_KEY, C1_PT), C1_CT);
    check("model App.B", aes_model(B_KEY, B_PT), B_CT);
    check("model zero", aes_model('0, '0), Z_CT);

    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset cypher_text", cypher_text, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_block("C.1", C1_KEY, C1_PT, C1_CT, 1'b0);
    run_block("App.B", B_KEY, B_PT, B_CT, 1'b0);
    check("App.B round key 10", dut.rk_q, B_RK10);
    run_block("isolation", C1_KEY, C1_PT, C1_CT, 1'b1);

    // Back-to-back with in_valid and out_ready held high.
    @(posedge clk); #1;
    key = '0; plain_text = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    key = C1_KEY; plain_text = C1_PT;
    wait_valid(30, 1'b0, lat, nb);
    c1 = cyc;
    check("b2b first ct", cypher_text, Z_CT);
    check("b2b first latency", lat, 10);
    @(negedge clk);
    check("b2b second accepted", busy, 1'b1);
    wait_valid(30, 1'b0, lat, nb);
    c2 = cyc;
    check("b2b second ct", cypher_text, C1_CT);
    check("b2b spacing", c2 - c1, 11);
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Backpressure: result must sit still while a new block is refused.
    run_block("pre-bp", B_KEY, B_PT, B_CT, 1'b0);
    @(posedge clk); #1;
    key = C1_KEY; plain_text = C1_PT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(30, 1'b0, lat, nb);
    hold = cypher_text;
    check("bp ct", hold, C1_CT);
    #1 key = '0; plain_text = '0; in_valid = 1'b1;
    stable = 1'b1;
    rdy_low = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (cypher_text !== hold || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
    end
    check("bp held stable", stable, 1'b1);
    check("bp in_ready low", rdy_low, 1'b1);
    #1 out_ready = 1'b1;
    #1 check("bp in_ready follows out_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("bp new block accepted", busy, 1'b1);
    wait_valid(30, 1'b0, lat, nb);
    check("bp new ct", cypher_text, Z_CT);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of round 5 discards the block.
    @(posedge clk); #1;
    key = C1_KEY; plain_text = C1_PT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b1; key = B_KEY; plain_text = B_PT;
    @(negedge clk);
    check("mid reset busy", busy, 1'b0);
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    check("aborted block silent", ov_seen, 1'b0);
    run_block("post-reset App.B", B_KEY, B_PT, B_CT, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
